// File: rtl/dlbf_coeffs_pkg.sv
// dlbf_coeffs_pkg
//   Shared types and helpers for the beamforming coefficient streamer and
//   the receive-side capture block (AXIS -> BRAM).
//   - state_e   : IDLE / RUN / DONE control FSM states
//   - widths    : control, address, beat counter and error counter widths
//   - next_addr : write/read pointer advance with rollover and RAM-end wrap
package dlbf_coeffs_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int CTRL_W     = 12;
    localparam int ADDR_W     = 16;
    localparam int BEAT_CNT_W = 24;
    localparam int ERR_CNT_W  = 16;

    // Wrap to 0 after the programmed rollover address, or at the physical
    // end of the RAM if rollover_addr was programmed past it.
    function automatic logic [ADDR_W-1:0] next_addr(
        input logic [ADDR_W-1:0] addr,
        input logic [ADDR_W-1:0] rollover,
        input logic [ADDR_W-1:0] last_addr
    );
        return (addr == rollover || addr == last_addr) ? '0 : addr + ADDR_W'(1);
    endfunction

endpackage

// File: rtl/dlbf_coeffs_blk_cnt.sv
// dlbf_coeffs_blk_cnt
//   Nested block/iteration counter. blk counts 0..block_size-1 and iter
//   advances at each block end. Sizes are captured on load so later changes
//   on the inputs have no effect until the next load.
//   Ports:
//     clk_i, rst_ni   : clock, asynchronous active-low reset
//     load_i          : clear counters, capture niter_i / block_size_i
//     step_i          : advance by one beat
//     niter_i         : number of blocks
//     block_size_i    : beats per block
//     blk_end_o       : current beat is the last of its block
//     all_done_o      : current beat is the last beat of the last block
module dlbf_coeffs_blk_cnt
    import dlbf_coeffs_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [CTRL_W-1:0] niter_i,
    input  logic [CTRL_W-1:0] block_size_i,
    output logic              blk_end_o,
    output logic              all_done_o
);

    logic [CTRL_W-1:0] blk_q, blk_d;
    logic [CTRL_W-1:0] iter_q, iter_d;
    logic [CTRL_W-1:0] bs_q, bs_d;
    logic [CTRL_W-1:0] ni_q, ni_d;

    assign blk_end_o  = (blk_q == bs_q - CTRL_W'(1));
    assign all_done_o = blk_end_o && (iter_q == ni_q - CTRL_W'(1));

    always_comb begin
        blk_d  = blk_q;
        iter_d = iter_q;
        bs_d   = bs_q;
        ni_d   = ni_q;
        if (load_i) begin
            blk_d  = '0;
            iter_d = '0;
            bs_d   = block_size_i;
            ni_d   = niter_i;
        end else if (step_i) begin
            if (blk_end_o) begin
                blk_d  = '0;
                iter_d = iter_q + CTRL_W'(1);
            end else begin
                blk_d  = blk_q + CTRL_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            blk_q  <= '0;
            iter_q <= '0;
            bs_q   <= '0;
            ni_q   <= '0;
        end else begin
            blk_q  <= blk_d;
            iter_q <= iter_d;
            bs_q   <= bs_d;
            ni_q   <= ni_d;
        end
    end

endmodule

// File: rtl/dlbf_coeffs_axis2ram_64b.sv
// dlbf_coeffs_axis2ram_64b
//   AXI4-Stream slave capturing AIE beamforming output blocks into a BRAM
//   write port. go latches niter/block_size/rollover_addr and starts a
//   capture of niter*block_size beats; done is sticky until the next go.
//   tlast is checked against the internal block count, not used to frame.
//   Ports:
//     s_axis_clk, s_axis_rst_n : clock, asynchronous active-low reset
//     go, niter, block_size, rollover_addr : control, sampled at go only
//     s_axis_t*                : AXI4-Stream slave (ready only in RUN)
//     ram_en/we/addr/din       : registered BRAM write port, 1-cycle latency
//     busy, done               : status (busy in RUN, done sticky)
//     addr_wire                : next address to be written
//     tlast_err_cnt, beat_cnt  : saturating statistics since go
module dlbf_coeffs_axis2ram_64b
    import dlbf_coeffs_pkg::*;
#(
    parameter int TDATA_WIDTH = 64,
    parameter int TKEEP_WIDTH = TDATA_WIDTH / 8,
    parameter int RAM_DEPTH   = 2048
) (
    input  logic                   s_axis_clk,
    input  logic                   s_axis_rst_n,
    input  logic                   go,
    input  logic [CTRL_W-1:0]      niter,
    input  logic [CTRL_W-1:0]      block_size,
    input  logic [ADDR_W-1:0]      rollover_addr,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic [TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic [TKEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                   s_axis_tlast,
    output logic                   ram_en,
    output logic [TKEEP_WIDTH-1:0] ram_we,
    output logic [ADDR_W-1:0]      ram_addr,
    output logic [TDATA_WIDTH-1:0] ram_din,
    output logic                   busy,
    output logic                   done,
    output logic [ADDR_W-1:0]      addr_wire,
    output logic [ERR_CNT_W-1:0]   tlast_err_cnt,
    output logic [BEAT_CNT_W-1:0]  beat_cnt
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_DEPTH - 1);

    state_e                  state_q, state_d;
    logic                    done_q, done_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [ADDR_W-1:0]       roll_q, roll_d;
    logic [BEAT_CNT_W-1:0]   beat_q, beat_d;
    logic [ERR_CNT_W-1:0]    err_q, err_d;
    logic                    ram_en_q, ram_en_d;
    logic [TKEEP_WIDTH-1:0]  ram_we_q, ram_we_d;
    logic [ADDR_W-1:0]       ram_addr_q, ram_addr_d;
    logic [TDATA_WIDTH-1:0]  ram_din_q, ram_din_d;

    logic start, hs, blk_end, all_done;

    // ready is a pure function of state so it drops the cycle after the
    // final handshake moves the FSM to DONE
    assign s_axis_tready = (state_q == RUN);
    assign busy          = (state_q == RUN);
    assign hs            = s_axis_tvalid && s_axis_tready;
    assign start         = go && (state_q != RUN);

    dlbf_coeffs_blk_cnt u_blk_cnt (
        .clk_i        (s_axis_clk),
        .rst_ni       (s_axis_rst_n),
        .load_i       (start),
        .step_i       (hs),
        .niter_i      (niter),
        .block_size_i (block_size),
        .blk_end_o    (blk_end),
        .all_done_o   (all_done)
    );

    always_comb begin
        state_d    = state_q;
        done_d     = done_q;
        addr_d     = addr_q;
        roll_d     = roll_q;
        beat_d     = beat_q;
        err_d      = err_q;
        ram_en_d   = 1'b0;
        ram_we_d   = '0;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;

        if (start) begin
            roll_d = rollover_addr;
            addr_d = '0;
            beat_d = '0;
            err_d  = '0;
            if (niter == '0 || block_size == '0) begin
                state_d = DONE;
                done_d  = 1'b1;
            end else begin
                state_d = RUN;
                done_d  = 1'b0;
            end
        end else if (hs) begin
            ram_en_d   = 1'b1;
            ram_we_d   = s_axis_tkeep;
            ram_addr_d = addr_q;
            ram_din_d  = s_axis_tdata;
            addr_d     = next_addr(addr_q, roll_q, LAST_ADDR);
            if (beat_q != '1)
                beat_d = beat_q + BEAT_CNT_W'(1);
            if ((s_axis_tlast != blk_end) && (err_q != '1))
                err_d = err_q + ERR_CNT_W'(1);
            // done registers on the same edge as the final RAM write
            if (all_done) begin
                state_d = DONE;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge s_axis_clk or negedge s_axis_rst_n) begin
        if (!s_axis_rst_n) begin
            state_q    <= IDLE;
            done_q     <= 1'b0;
            addr_q     <= '0;
            roll_q     <= '0;
            beat_q     <= '0;
            err_q      <= '0;
            ram_en_q   <= 1'b0;
            ram_we_q   <= '0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
        end else begin
            state_q    <= state_d;
            done_q     <= done_d;
            addr_q     <= addr_d;
            roll_q     <= roll_d;
            beat_q     <= beat_d;
            err_q      <= err_d;
            ram_en_q   <= ram_en_d;
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
        end
    end

    assign done          = done_q;
    assign addr_wire     = addr_q;
    assign beat_cnt      = beat_q;
    assign tlast_err_cnt = err_q;
    assign ram_en        = ram_en_q;
    assign ram_we        = ram_we_q;
    assign ram_addr      = ram_addr_q;
    assign ram_din       = ram_din_q;

endmodule

// File: tb/tb_dlbf_coeffs_axis2ram_64b.sv
// Directed bench for dlbf_coeffs_axis2ram_64b: stimulus drives just after
// the rising edge; a monitor logs RAM writes and handshakes on the falling
// edge with a cycle stamp so write latency can be checked.
module tb_dlbf_coeffs_axis2ram_64b;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        go = 1'b0;
    logic [11:0] niter = '0;
    logic [11:0] block_size = '0;
    logic [15:0] rollover_addr = '0;
    logic        tvalid = 1'b0;
    logic        tready;
    logic [63:0] tdata = '0;
    logic [7:0]  tkeep = '0;
    logic        tlast = 1'b0;
    logic        ram_en;
    logic [7:0]  ram_we;
    logic [15:0] ram_addr;
    logic [63:0] ram_din;
    logic        busy, done;
    logic [15:0] addr_wire, tlast_err_cnt;
    logic [23:0] beat_cnt;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    logic [15:0] wr_addr[$];
    logic [63:0] wr_data[$];
    logic [7:0]  wr_we[$];
    int          wr_cyc[$];
    int          hs_cyc[$];

    dlbf_coeffs_axis2ram_64b dut (
        .s_axis_clk    (clk),
        .s_axis_rst_n  (rst_n),
        .go            (go),
        .niter         (niter),
        .block_size    (block_size),
        .rollover_addr (rollover_addr),
        .s_axis_tvalid (tvalid),
        .s_axis_tready (tready),
        .s_axis_tdata  (tdata),
        .s_axis_tkeep  (tkeep),
        .s_axis_tlast  (tlast),
        .ram_en        (ram_en),
        .ram_we        (ram_we),
        .ram_addr      (ram_addr),
        .ram_din       (ram_din),
        .busy          (busy),
        .done          (done),
        .addr_wire     (addr_wire),
        .tlast_err_cnt (tlast_err_cnt),
        .beat_cnt      (beat_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ram_en) begin
            wr_addr.push_back(ram_addr);
            wr_data.push_back(ram_din);
            wr_we.push_back(ram_we);
            wr_cyc.push_back(cyc);
        end
        if (tvalid && tready) hs_cyc.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_log();
        wr_addr.delete(); wr_data.delete(); wr_we.delete();
        wr_cyc.delete(); hs_cyc.delete();
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic pulse_go(input logic [11:0] ni, input logic [11:0] bs, input logic [15:0] ro);
        niter = ni; block_size = bs; rollover_addr = ro;
        go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    // Send n beats, data=base+i, tlast from mask bit i; optional random idle
    // cycles before each beat. Each beat waits at most 50 cycles for ready.
    task automatic stream(input int n, input int base, input logic [31:0] lmask,
                          input logic [7:0] keep, input bit gaps);
        logic ok;
        int   to;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 1) == 1) begin
                    tvalid = 1'b0;
                    tick();
                end
            end
            tvalid = 1'b1;
            tdata  = 64'(base + i);
            tkeep  = keep;
            tlast  = lmask[i];
            to = 0;
            do begin
                @(negedge clk);
                ok = tready;
                tick();
                to++;
            end while (!ok && to < 50);
            if (!ok) chk("ready_timeout", 64'(ok), 64'd1);
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic chk_writes(input string tag, input int n, input logic [15:0] a0, input logic [15:0] roll);
        logic [15:0] a;
        a = a0;
        chk({tag, "_nwr"}, 64'(wr_addr.size()), 64'(n));
        for (int i = 0; i < n && i < wr_addr.size(); i++) begin
            chk({tag, "_addr"}, 64'(wr_addr[i]), 64'(a));
            chk({tag, "_data"}, wr_data[i], 64'(i));
            chk({tag, "_we"}, 64'(wr_we[i]), 64'hFF);
            a = (a == roll) ? 16'd0 : a + 16'd1;
        end
    endtask

    initial begin
        // reset state
        #12;
        chk("rst_tready", 64'(tready), 0);
        chk("rst_ram_en", 64'(ram_en), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_addr", 64'(addr_wire), 0);
        chk("rst_beats", 64'(beat_cnt), 0);
        rst_n = 1'b1;
        tick(); tick();

        // T1: 2 blocks of 4, clean tlast
        clr_log();
        pulse_go(12'd2, 12'd4, 16'd15);
        chk("t1_busy", 64'(busy), 1);
        stream(8, 0, 32'h88, 8'hFF, 1'b0);
        chk("t1_done_with_last", 64'(done), 1);
        chk("t1_last_en", 64'(ram_en), 1);
        chk("t1_last_addr", 64'(ram_addr), 7);
        chk("t1_tready_low", 64'(tready), 0);
        chk("t1_err", 64'(tlast_err_cnt), 0);
        chk("t1_beats", 64'(beat_cnt), 8);
        chk("t1_addr_wire", 64'(addr_wire), 8);
        tick();
        chk_writes("t1", 8, 16'd0, 16'd15);

        // T2: rollover at 5; go from DONE restarts
        clr_log();
        pulse_go(12'd2, 12'd4, 16'd5);
        chk("t2_done_cleared", 64'(done), 0);
        stream(8, 0, 32'h88, 8'hFF, 1'b0);
        chk("t2_done", 64'(done), 1);
        chk("t2_addr_wire", 64'(addr_wire), 2);
        tick();
        chk_writes("t2", 8, 16'd0, 16'd5);

        // T3: early tlast at beat 1, missing at beat 3
        clr_log();
        pulse_go(12'd1, 12'd4, 16'd15);
        stream(3, 0, 32'h2, 8'hFF, 1'b0);
        chk("t3_not_done_yet", 64'(done), 0);
        stream(1, 3, 32'h0, 8'hFF, 1'b0);
        chk("t3_done", 64'(done), 1);
        chk("t3_err", 64'(tlast_err_cnt), 2);
        tick();
        chk("t3_nwr", 64'(wr_addr.size()), 4);

        // T4: tkeep=0 beats are counted and advance address, no byte enables
        clr_log();
        pulse_go(12'd1, 12'd2, 16'd15);
        stream(2, 0, 32'h2, 8'h00, 1'b0);
        chk("t4_done", 64'(done), 1);
        chk("t4_addr_wire", 64'(addr_wire), 2);
        chk("t4_beats", 64'(beat_cnt), 2);
        tick();
        chk("t4_nen", 64'(wr_we.size()), 2);
        for (int i = 0; i < wr_we.size(); i++) chk("t4_we0", 64'(wr_we[i]), 0);

        // T5: random tvalid gaps, 3 blocks of 5
        clr_log();
        pulse_go(12'd3, 12'd5, 16'd100);
        stream(15, 0, 32'h4210, 8'hFF, 1'b1);
        chk("t5_done", 64'(done), 1);
        chk("t5_err", 64'(tlast_err_cnt), 0);
        tick(); tick();
        chk_writes("t5", 15, 16'd0, 16'd100);
        chk("t5_nhs", 64'(hs_cyc.size()), 15);
        for (int i = 0; i < wr_cyc.size() && i < hs_cyc.size(); i++)
            chk("t5_latency", 64'(wr_cyc[i]), 64'(hs_cyc[i] + 1));

        // T6: reset after 3 of 8 beats
        clr_log();
        pulse_go(12'd1, 12'd8, 16'd15);
        stream(3, 0, 32'h0, 8'hFF, 1'b0);
        tvalid = 1'b1; tdata = 64'd3; tkeep = 8'hFF;
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_en", 64'(ram_en), 0);
        chk("t6_rst_we", 64'(ram_we), 0);
        chk("t6_rst_tready", 64'(tready), 0);
        chk("t6_rst_busy", 64'(busy), 0);
        chk("t6_rst_addr", 64'(addr_wire), 0);
        chk("t6_rst_beats", 64'(beat_cnt), 0);
        clr_log();
        tick(); tick(); tick();
        chk("t6_no_wr_in_rst", 64'(wr_addr.size()), 0);
        tvalid = 1'b0;
        rst_n = 1'b1;
        tick();
        pulse_go(12'd1, 12'd8, 16'd15);
        stream(8, 0, 32'h80, 8'hFF, 1'b0);
        chk("t6_done", 64'(done), 1);
        tick();
        chk_writes("t6", 8, 16'd0, 16'd15);

        // T7: niter=0 goes straight to DONE, ready never rises
        pulse_go(12'd0, 12'd4, 16'd15);
        chk("t7_done", 64'(done), 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t7_tready", 64'(tready), 0);
        end
        tick();

        // T8: go during RUN is ignored
        clr_log();
        pulse_go(12'd1, 12'd4, 16'd15);
        stream(2, 0, 32'h0, 8'hFF, 1'b0);
        pulse_go(12'd2, 12'd8, 16'd1);
        chk("t8_still_busy", 64'(busy), 1);
        stream(2, 2, 32'h2, 8'hFF, 1'b0);
        chk("t8_done", 64'(done), 1);
        chk("t8_beats", 64'(beat_cnt), 4);
        chk("t8_addr_wire", 64'(addr_wire), 4);
        chk("t8_err", 64'(tlast_err_cnt), 0);
        tick();
        chk_writes("t8", 4, 16'd0, 16'd15);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
